// File: rtl/soc_onchip_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : soc_onchip_mem_pkg
// Purpose : Shared helpers for the banked dual-port on-chip memory:
//           bank-select width, byte parity and arbiter priority encoding.
// Ports   : none (package)
// Options : SOC_ONCHIP_MEM_PARITY_EN (parity storage, see top level)
// Revision: 1.0 - initial release
// ============================================================================
package soc_onchip_mem_pkg;

  // Arbiter priority encoding: which port wins the next same-bank conflict.
  localparam logic PRIO_S1 = 1'b0;
  localparam logic PRIO_S2 = 1'b1;

  // Number of address LSBs used as bank select (ceil(log2(num_banks))).
  function automatic int bank_w(input int num_banks);
    int w;
    w = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << w) < num_banks) w++;
    end
    return w;
  endfunction

  // Even parity bit: makes the total number of ones in {bit, data} even.
  function automatic logic byte_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_onchip_mem_bank.sv
`default_nettype none
// ============================================================================
// Module  : soc_onchip_mem_bank
// Purpose : Single-port, byte-enabled synchronous RAM bank. One access per
//           cycle; a write takes priority over a read on the same access.
//           Read data is registered (one cycle latency) and holds until the
//           next read access to this bank.
// Ports   : clk_i    - clock
//           en_i     - access strobe for this cycle
//           we_i     - 1: write, 0: read
//           addr_i   - bank-local word address
//           be_i     - byte lanes to write
//           wdata_i  - write data
//           wpar_i   - per-lane parity to store (SOC_ONCHIP_MEM_PARITY_EN only)
//           rpar_o   - per-lane parity read back (SOC_ONCHIP_MEM_PARITY_EN only)
//           rdata_o  - registered read data
// Options : SOC_ONCHIP_MEM_PARITY_EN adds one parity bit per byte lane.
// Notes   : Contents are deliberately not reset. INIT_FILE names the
//           word-interleaved preload image applied by the implementation flow.
// Revision: 1.0 - initial release
// ============================================================================
module soc_onchip_mem_bank #(
  parameter int DATA_W    = 32,
  parameter int DEPTH_W   = 14,
  parameter     INIT_FILE = "soc_onchip_mem.hex"
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_W-1:0]    addr_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [DATA_W-1:0]     wdata_i,
`ifdef SOC_ONCHIP_MEM_PARITY_EN
  input  logic [DATA_W/8-1:0]   wpar_i,
  output logic [DATA_W/8-1:0]   rpar_o,
`endif
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < NB; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

`ifdef SOC_ONCHIP_MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] rpar_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < NB; i++) begin
          if (be_i[i]) par_q[addr_i][i] <= wpar_i[i];
        end
      end else begin
        rpar_q <= par_q[addr_i];
      end
    end
  end

  assign rpar_o = rpar_q;
`endif

endmodule
`default_nettype wire

// File: rtl/soc_onchip_mem_dualport_banked.sv
`default_nettype none
// ============================================================================
// Module  : soc_onchip_mem_dualport_banked
// Purpose : On-chip data memory with two Avalon-MM slave ports over
//           NUM_BANKS word-interleaved single-port RAM banks. Accesses to
//           different banks proceed in parallel; same-bank accesses are
//           arbitrated round-robin with waitrequest back-pressure.
// Ports   : clk_i, reset_i (async, active high), clken_i, reset_req_i
//           sN_address_i, sN_byteenable_i, sN_chipselect_i, sN_read_i,
//           sN_write_i, sN_writedata_i                       (N = 1, 2)
//           sN_waitrequest_o, sN_readdata_o, sN_readdatavalid_o
//           parity_inject_i, sN_parity_err_o (SOC_ONCHIP_MEM_PARITY_EN only)
// Options : SOC_ONCHIP_MEM_PARITY_EN - per-byte even parity storage/check.
//           OUT_REG = 1 adds an output register (read latency 2).
// Revision: 1.0 - initial release
// ============================================================================
module soc_onchip_mem_dualport_banked
  import soc_onchip_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 15,
  parameter int NUM_BANKS = 2,
  parameter int OUT_REG   = 0,
  parameter     INIT_FILE = "soc_onchip_mem.hex"
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clken_i,
  input  logic                  reset_req_i,
  input  logic [ADDR_W-1:0]     s1_address_i,
  input  logic [DATA_W/8-1:0]   s1_byteenable_i,
  input  logic                  s1_chipselect_i,
  input  logic                  s1_read_i,
  input  logic                  s1_write_i,
  input  logic [DATA_W-1:0]     s1_writedata_i,
  output logic                  s1_waitrequest_o,
  output logic [DATA_W-1:0]     s1_readdata_o,
  output logic                  s1_readdatavalid_o,
  input  logic [ADDR_W-1:0]     s2_address_i,
  input  logic [DATA_W/8-1:0]   s2_byteenable_i,
  input  logic                  s2_chipselect_i,
  input  logic                  s2_read_i,
  input  logic                  s2_write_i,
  input  logic [DATA_W-1:0]     s2_writedata_i,
`ifdef SOC_ONCHIP_MEM_PARITY_EN
  input  logic                  parity_inject_i,
  output logic                  s1_parity_err_o,
  output logic                  s2_parity_err_o,
`endif
  output logic                  s2_waitrequest_o,
  output logic [DATA_W-1:0]     s2_readdata_o,
  output logic                  s2_readdatavalid_o
);

  localparam int NB      = DATA_W / 8;
  localparam int BANK_W  = bank_w(NUM_BANKS);
  localparam int SEL_W   = (BANK_W > 0) ? BANK_W : 1;
  localparam int LOCAL_W = ADDR_W - BANK_W;
  localparam logic [ADDR_W-1:0] BANK_MASK = ADDR_W'(NUM_BANKS - 1);

  // --------------------------------------------------------------------------
  // Port signals gathered into arrays (index 0 = s1, index 1 = s2)
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]  addr      [2];
  logic [NB-1:0]      be        [2];
  logic [DATA_W-1:0]  wdata     [2];
  logic [1:0]         cs, rd, wr;
  logic [SEL_W-1:0]   bank_idx  [2];
  logic [LOCAL_W-1:0] local_addr[2];
  logic [NB-1:0]      wpar      [2];

  assign addr[0]  = s1_address_i;     assign addr[1]  = s2_address_i;
  assign be[0]    = s1_byteenable_i;  assign be[1]    = s2_byteenable_i;
  assign wdata[0] = s1_writedata_i;   assign wdata[1] = s2_writedata_i;
  assign cs       = {s2_chipselect_i, s1_chipselect_i};
  assign rd       = {s2_read_i,       s1_read_i};
  assign wr       = {s2_write_i,      s1_write_i};

  logic       en;
  logic [1:0] req, grant, rd_issue, waitreq;
  logic       conflict;
  logic       prio_q;

  assign en = clken_i & ~reset_req_i;

  for (genvar p = 0; p < 2; p++) begin : g_decode
    assign bank_idx[p]   = SEL_W'(addr[p] & BANK_MASK);
    assign local_addr[p] = LOCAL_W'(addr[p] >> BANK_W);
    assign req[p]        = cs[p] & (rd[p] | wr[p]) & en;
    // Read together with write is treated as a write: no read data returned.
    assign rd_issue[p]   = grant[p] & ~wr[p];
    assign waitreq[p]    = cs[p] & (rd[p] | wr[p]) & ~grant[p];
`ifdef SOC_ONCHIP_MEM_PARITY_EN
    // Lane 0 parity can be inverted on demand to exercise the checker.
    for (genvar i = 0; i < NB; i++) begin : g_wpar
      if (i == 0) begin : g_lane0
        assign wpar[p][i] = byte_parity(wdata[p][8*i +: 8]) ^ parity_inject_i;
      end else begin : g_laneN
        assign wpar[p][i] = byte_parity(wdata[p][8*i +: 8]);
      end
    end
`else
    assign wpar[p] = '0;
`endif
  end

  // --------------------------------------------------------------------------
  // Arbiter: only a same-bank collision is arbitrated; prio flips after each
  // collision so the loser wins the next one.
  // --------------------------------------------------------------------------
  assign conflict = req[0] & req[1] & (bank_idx[0] == bank_idx[1]);
  assign grant[0] = req[0] & (~conflict | (prio_q == PRIO_S1));
  assign grant[1] = req[1] & (~conflict | (prio_q == PRIO_S2));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prio_q <= PRIO_S1;
    end else if (conflict) begin
      prio_q <= ~prio_q;
    end
  end

  assign s1_waitrequest_o = waitreq[0];
  assign s2_waitrequest_o = waitreq[1];

  // --------------------------------------------------------------------------
  // Banks: each bank is driven by whichever port was granted into it.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  logic [NB-1:0]     bank_rpar  [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic               hit0, hit1;
    logic               b_en, b_we;
    logic [LOCAL_W-1:0] b_addr;
    logic [NB-1:0]      b_be;
    logic [DATA_W-1:0]  b_wdata;
    logic [NB-1:0]      b_wpar;

    assign hit0    = grant[0] & (bank_idx[0] == SEL_W'(b));
    assign hit1    = grant[1] & (bank_idx[1] == SEL_W'(b));
    assign b_en    = hit0 | hit1;
    assign b_we    = hit0 ? wr[0]         : wr[1];
    assign b_addr  = hit0 ? local_addr[0] : local_addr[1];
    assign b_be    = hit0 ? be[0]         : be[1];
    assign b_wdata = hit0 ? wdata[0]      : wdata[1];
    assign b_wpar  = hit0 ? wpar[0]       : wpar[1];

    soc_onchip_mem_bank #(
      .DATA_W    (DATA_W),
      .DEPTH_W   (LOCAL_W),
      .INIT_FILE (INIT_FILE)
    ) u_bank (
      .clk_i   (clk_i),
      .en_i    (b_en),
      .we_i    (b_we),
      .addr_i  (b_addr),
      .be_i    (b_be),
      .wdata_i (b_wdata),
`ifdef SOC_ONCHIP_MEM_PARITY_EN
      .wpar_i  (b_wpar),
      .rpar_o  (bank_rpar[b]),
`endif
      .rdata_o (bank_rdata[b])
    );

`ifndef SOC_ONCHIP_MEM_PARITY_EN
    assign bank_rpar[b] = b_wpar;
`endif
  end

  // --------------------------------------------------------------------------
  // Per-port read pipeline. Stage 0 tracks which bank holds this port's read
  // data; all stages advance only on enabled cycles, and valid is shown only
  // on an enabled cycle so a frozen pipeline never repeats a beat.
  // --------------------------------------------------------------------------
  logic [1:0]        rvalid;
  logic [1:0]        perr;
  logic [DATA_W-1:0] rdata [2];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              v0_q;
    logic [SEL_W-1:0]  bank0_q;
    logic [DATA_W-1:0] mux_data;
    logic [NB-1:0]     mux_par;
    logic              mismatch;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        v0_q    <= 1'b0;
        bank0_q <= '0;
      end else if (en) begin
        v0_q    <= rd_issue[p];
        bank0_q <= bank_idx[p];
      end
    end

    always_comb begin
      mux_data = '0;
      mux_par  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank0_q == SEL_W'(b)) begin
          mux_data = bank_rdata[b];
          mux_par  = bank_rpar[b];
        end
      end
    end

`ifdef SOC_ONCHIP_MEM_PARITY_EN
    always_comb begin
      mismatch = 1'b0;
      for (int i = 0; i < NB; i++) begin
        if (byte_parity(mux_data[8*i +: 8]) != mux_par[i]) mismatch = 1'b1;
      end
    end
`else
    assign mismatch = 1'b0 & (|mux_par);
`endif

    if (OUT_REG == 0) begin : g_lat1
      // Bank output may be overwritten by the other port later, so the last
      // delivered word is captured to keep readdata stable between beats.
      logic [DATA_W-1:0] hold_q;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          hold_q <= '0;
        end else if (v0_q && en) begin
          hold_q <= mux_data;
        end
      end

      assign rvalid[p] = v0_q & en;
      assign rdata[p]  = rvalid[p] ? mux_data : hold_q;
      assign perr[p]   = rvalid[p] & mismatch;
    end else begin : g_lat2
      logic              v1_q;
      logic [DATA_W-1:0] d1_q;
      logic              e1_q;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          v1_q <= 1'b0;
          d1_q <= '0;
          e1_q <= 1'b0;
        end else if (en) begin
          v1_q <= v0_q;
          if (v0_q) begin
            d1_q <= mux_data;
            e1_q <= mismatch;
          end
        end
      end

      assign rvalid[p] = v1_q & en;
      assign rdata[p]  = d1_q;
      assign perr[p]   = rvalid[p] & e1_q;
    end
  end

  assign s1_readdatavalid_o = rvalid[0];
  assign s2_readdatavalid_o = rvalid[1];
  assign s1_readdata_o      = rdata[0];
  assign s2_readdata_o      = rdata[1];

`ifdef SOC_ONCHIP_MEM_PARITY_EN
  assign s1_parity_err_o = perr[0];
  assign s2_parity_err_o = perr[1];
`else
  logic unused_perr;
  assign unused_perr = |perr;
`endif

endmodule
`default_nettype wire
